cic_rate_ctrl: RTL and testbench

CIC_RATE_CTRL -- requirements
Module: cic_rate_ctrl

---
 rtl/cic_ctrl_pkg.sv | 16 +
 rtl/cic_rate_ctrl.sv | 118 +++++++++++
 tb/tb_cic_rate_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cic_ctrl_pkg.sv
// State type and encodings for the CIC decimation-rate controller.
package cic_ctrl_pkg;

    localparam logic [1:0] ENC_RUN    = 2'd0;
    localparam logic [1:0] ENC_DRAIN  = 2'd1;
    localparam logic [1:0] ENC_APPLY  = 2'd2;
    localparam logic [1:0] ENC_SETTLE = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = ENC_RUN,
        ST_DRAIN  = ENC_DRAIN,
        ST_APPLY  = ENC_APPLY,
        ST_SETTLE = ENC_SETTLE
    } cic_state_t;

endpackage

// File: rtl/cic_rate_ctrl.sv
// Rate-change sequencer for a CIC decimator: blocks input, issues the new rate,
// then discards the filter's transient outputs before resuming.
module cic_rate_ctrl #(
    parameter int INP_DW       = 32,
    parameter int RATE_DW      = 32,
    parameter int CIC_R        = 10,
    parameter int CIC_N        = 7,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [RATE_DW-1:0]       s_axis_cfg_tdata,
    input  logic                     s_axis_cfg_tvalid,
    output logic                     s_axis_cfg_tready,
    input  logic signed [INP_DW-1:0] s_axis_in_tdata,
    input  logic                     s_axis_in_tvalid,
    output logic                     s_axis_in_tready,
    output logic [INP_DW-1:0]        m_axis_cic_tdata,
    output logic                     m_axis_cic_tvalid,
    output logic [RATE_DW-1:0]       m_axis_rate_tdata,
    output logic                     m_axis_rate_tvalid,
    input  logic [INP_DW-1:0]        s_axis_cic_tdata,
    input  logic                     s_axis_cic_tvalid,
    output logic [INP_DW-1:0]        m_axis_out_tdata,
    output logic                     m_axis_out_tvalid,
    output logic [RATE_DW-1:0]       rate_current,
    output logic                     busy,
    output logic                     cfg_err
);
    import cic_ctrl_pkg::*;

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int DISC_W  = $clog2(CIC_N + 1);

    cic_state_t          r_state;
    cic_state_t          w_state_nxt;
    logic [RATE_DW-1:0]  r_pending;
    logic [RATE_DW-1:0]  r_rate_cur;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic [DISC_W-1:0]   r_disc_cnt;
    logic [INP_DW-1:0]   r_out_data;
    logic                r_out_vld;
    logic                r_cfg_err;

    logic                w_run;
    logic                w_settle;
    logic                w_cfg_hs;
    logic                w_cfg_bad;
    logic                w_cfg_take;
    logic                w_fwd;

    assign w_run      = (r_state == ST_RUN);
    assign w_settle   = (r_state == ST_SETTLE);
    assign w_cfg_hs   = s_axis_cfg_tvalid && w_run;
    assign w_cfg_bad  = (s_axis_cfg_tdata == '0) || (s_axis_cfg_tdata > RATE_DW'(CIC_R));
    assign w_cfg_take = w_cfg_hs && !w_cfg_bad && (s_axis_cfg_tdata != r_rate_cur);
    assign w_fwd      = s_axis_cic_tvalid && !w_settle;

    assign s_axis_cfg_tready = w_run;
    assign s_axis_in_tready  = w_run || w_settle;
    assign busy              = !w_run;
    assign m_axis_cic_tdata  = s_axis_in_tdata;
    assign m_axis_cic_tvalid = s_axis_in_tvalid && s_axis_in_tready;
    // Reset parks the FSM in APPLY; the pulse is masked so it only fires once reset is released.
    assign m_axis_rate_tvalid = (r_state == ST_APPLY) && reset_n;
    assign m_axis_rate_tdata  = r_pending;
    assign m_axis_out_tdata   = r_out_data;
    assign m_axis_out_tvalid  = r_out_vld;
    assign rate_current       = r_rate_cur;
    assign cfg_err            = r_cfg_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_cfg_take) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (r_drain_cnt <= DRAIN_W'(1)) w_state_nxt = ST_APPLY;
            ST_APPLY:  w_state_nxt = ST_SETTLE;
            ST_SETTLE: if ((r_disc_cnt == '0) ||
                           (s_axis_cic_tvalid && (r_disc_cnt == DISC_W'(1))))
                           w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_APPLY;
            r_pending   <= RATE_DW'(CIC_R);
            r_rate_cur  <= RATE_DW'(CIC_R);
            r_drain_cnt <= '0;
            r_disc_cnt  <= '0;
            r_out_data  <= '0;
            r_out_vld   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= w_cfg_hs && w_cfg_bad;
            r_out_vld <= w_fwd;
            if (w_fwd)
                r_out_data <= s_axis_cic_tdata;
            case (r_state)
                ST_RUN: if (w_cfg_take) begin
                    r_pending   <= s_axis_cfg_tdata;
                    r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
                end
                ST_DRAIN:  r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                ST_APPLY: begin
                    r_rate_cur <= r_pending;
                    r_disc_cnt <= DISC_W'(CIC_N);
                end
                ST_SETTLE: if (s_axis_cic_tvalid && (r_disc_cnt != '0))
                    r_disc_cnt <= r_disc_cnt - DISC_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Bench for cic_rate_ctrl: directed rate-change scenarios plus random traffic,
// checked cycle by cycle against a counter-based behavioural model.
module tb_cic_rate_ctrl;

    localparam int INP_DW  = 32;
    localparam int RATE_DW = 32;
    localparam int CIC_R   = 10;
    localparam int CIC_N   = 7;
    localparam int DRAIN   = 8;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [RATE_DW-1:0]       s_axis_cfg_tdata = '0;
    logic                     s_axis_cfg_tvalid = 1'b0;
    logic                     s_axis_cfg_tready;
    logic signed [INP_DW-1:0] s_axis_in_tdata = '0;
    logic                     s_axis_in_tvalid = 1'b0;
    logic                     s_axis_in_tready;
    logic [INP_DW-1:0]        m_axis_cic_tdata;
    logic                     m_axis_cic_tvalid;
    logic [RATE_DW-1:0]       m_axis_rate_tdata;
    logic                     m_axis_rate_tvalid;
    logic [INP_DW-1:0]        s_axis_cic_tdata = '0;
    logic                     s_axis_cic_tvalid = 1'b0;
    logic [INP_DW-1:0]        m_axis_out_tdata;
    logic                     m_axis_out_tvalid;
    logic [RATE_DW-1:0]       rate_current;
    logic                     busy;
    logic                     cfg_err;

    cic_rate_ctrl #(
        .INP_DW(INP_DW), .RATE_DW(RATE_DW), .CIC_R(CIC_R), .CIC_N(CIC_N), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axis_cfg_tdata(s_axis_cfg_tdata), .s_axis_cfg_tvalid(s_axis_cfg_tvalid),
        .s_axis_cfg_tready(s_axis_cfg_tready),
        .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
        .s_axis_in_tready(s_axis_in_tready),
        .m_axis_cic_tdata(m_axis_cic_tdata), .m_axis_cic_tvalid(m_axis_cic_tvalid),
        .m_axis_rate_tdata(m_axis_rate_tdata), .m_axis_rate_tvalid(m_axis_rate_tvalid),
        .s_axis_cic_tdata(s_axis_cic_tdata), .s_axis_cic_tvalid(s_axis_cic_tvalid),
        .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tvalid(m_axis_out_tvalid),
        .rate_current(rate_current), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    // Model: remaining blocked cycles, one apply cycle, remaining outputs to drop.
    int          m_blk  = 0;
    bit          m_apl  = 1'b1;
    int          m_drop = 0;
    logic [31:0] m_pend = CIC_R;
    logic [31:0] m_rate = CIC_R;
    logic [31:0] m_out_data = '0;
    bit          m_out_vld = 1'b0;
    bit          m_err = 1'b0;

    function automatic bit m_run();
        return (m_blk == 0) && !m_apl && (m_drop == 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rnd_data();
        s_axis_in_tdata   = $urandom;
        s_axis_in_tvalid  = 1'($urandom_range(0, 1));
        s_axis_cic_tdata  = $urandom;
        s_axis_cic_tvalid = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        bit run, in_rdy, bad, rv;
        @(negedge clk);
        run    = m_run();
        in_rdy = run || (m_drop > 0);
        rv     = m_apl && reset_n;
        chk("cfg_tready", 64'(s_axis_cfg_tready), 64'(run));
        chk("in_tready", 64'(s_axis_in_tready), 64'(in_rdy));
        chk("busy", 64'(busy), 64'(!run));
        chk("cic_tvalid", 64'(m_axis_cic_tvalid), 64'(s_axis_in_tvalid && in_rdy));
        chk("cic_tdata", 64'(m_axis_cic_tdata), 64'(unsigned'(s_axis_in_tdata)));
        chk("rate_tvalid", 64'(m_axis_rate_tvalid), 64'(rv));
        if (rv) chk("rate_tdata", 64'(m_axis_rate_tdata), 64'(m_pend));
        chk("rate_current", 64'(rate_current), 64'(m_rate));
        chk("cfg_err", 64'(cfg_err), 64'(m_err));
        chk("out_tvalid", 64'(m_axis_out_tvalid), 64'(m_out_vld));
        chk("out_tdata", 64'(m_axis_out_tdata), 64'(m_out_data));
        @(posedge clk);
        bad = (s_axis_cfg_tdata == 0) || (s_axis_cfg_tdata > CIC_R);
        if (!reset_n) begin
            m_blk = 0; m_apl = 1'b1; m_drop = 0; m_pend = CIC_R; m_rate = CIC_R;
            m_out_data = '0; m_out_vld = 1'b0; m_err = 1'b0;
        end else begin
            m_err     = run && s_axis_cfg_tvalid && bad;
            m_out_vld = s_axis_cic_tvalid && (m_drop == 0);
            if (m_out_vld) m_out_data = s_axis_cic_tdata;
            if (m_apl) begin
                m_rate = m_pend; m_apl = 1'b0; m_drop = CIC_N;
            end else if (m_blk > 0) begin
                m_blk--;
                if (m_blk == 0) m_apl = 1'b1;
            end else if (m_drop > 0) begin
                if (s_axis_cic_tvalid) m_drop--;
            end else if (run && s_axis_cfg_tvalid && !bad && s_axis_cfg_tdata != m_rate) begin
                m_pend = s_axis_cfg_tdata; m_blk = DRAIN;
            end
        end
        #1;
    endtask

    task automatic settle(input int budget);
        int n = 0;
        while (!m_run() && n < budget) begin
            rnd_data();
            tick();
            n++;
        end
        chk("settle_bound", 64'(m_run()), 64'd1);
    endtask

    task automatic cfg_once(input logic [31:0] v);
        rnd_data();
        s_axis_cfg_tdata  = v;
        s_axis_cfg_tvalid = 1'b1;
        tick();
        s_axis_cfg_tvalid = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin rnd_data(); tick(); end
        reset_n = 1'b1;
        rnd_data();
        tick();
        chk("rst_release_busy", 64'(busy), 64'd1);
        settle(200);
        chk("rst_rate", 64'(rate_current), 64'd10);
        for (int i = 0; i < 10; i++) begin rnd_data(); tick(); end

        // Equal to current rate: no sequence
        cfg_once(32'd10);
        for (int i = 0; i < 4; i++) begin rnd_data(); tick(); end

        // Out-of-range requests
        cfg_once(32'd0);
        rnd_data(); tick();
        cfg_once(32'd11);
        rnd_data(); tick();

        // Change to 5 with a concurrent input sample
        rnd_data();
        s_axis_in_tvalid  = 1'b1;
        s_axis_cfg_tdata  = 32'd5;
        s_axis_cfg_tvalid = 1'b1;
        tick();
        s_axis_cfg_tvalid = 1'b0;
        settle(200);
        chk("rate_after_5", 64'(rate_current), 64'd5);

        // Change to 7, then keep a request for 3 pending through the whole sequence
        cfg_once(32'd7);
        s_axis_cfg_tdata  = 32'd3;
        s_axis_cfg_tvalid = 1'b1;
        for (int n = 0; n < 200 && !m_run(); n++) begin
            rnd_data(); tick();
        end
        rnd_data(); tick();
        s_axis_cfg_tvalid = 1'b0;
        settle(200);
        chk("rate_after_3", 64'(rate_current), 64'd3);

        // Reset in the middle of draining a request for 4
        cfg_once(32'd4);
        for (int i = 0; i < 3; i++) begin rnd_data(); tick(); end
        reset_n = 1'b0;
        rnd_data(); tick();
        reset_n = 1'b1;
        settle(200);
        chk("rate_after_abort", 64'(rate_current), 64'd10);

        // Random traffic with occasional requests and resets
        for (int i = 0; i < 600; i++) begin
            rnd_data();
            s_axis_cfg_tvalid = ($urandom_range(0, 9) == 0);
            s_axis_cfg_tdata  = $urandom_range(0, 12);
            reset_n           = ($urandom_range(0, 249) != 0);
            tick();
        end
        reset_n = 1'b1;
        s_axis_cfg_tvalid = 1'b0;
        settle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
